// File: rtl/uart_rx_pkg.sv
// Shared types and frame-geometry helpers for the UART receive start-bit front end.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    START_CHECK = 2'd1,
    HOLDOFF     = 2'd2,
    WAIT_IDLE   = 2'd3
  } rx_start_state_t;

  function automatic int frame_bits_f(input int data_width, input int parity_en, input int stop_bits);
    return 1 + data_width + parity_en + stop_bits;
  endfunction

  function automatic int mid_f(input int oversample);
    return oversample / 2;
  endfunction

endpackage

// File: rtl/uart_tick_counter.sv
// Mod-OVERSAMPLE tick counter with a bit-index counter that advances on an externally gated wrap.
module uart_tick_counter #(
  parameter int OVERSAMPLE = 16,
  parameter int FRAME_BITS = 11,
  parameter int TW         = $clog2(OVERSAMPLE),
  parameter int BW         = $clog2(FRAME_BITS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_i,
  input  logic          advance_i,
  input  logic          bit_inc_i,
  output logic [TW-1:0] tick_cnt_o,
  output logic [BW-1:0] bit_index_o,
  output logic          wrap_o
);

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [BW-1:0] bit_index_q, bit_index_d;

  assign wrap_o      = advance_i && (tick_cnt_q == TW'(OVERSAMPLE - 1));
  assign tick_cnt_o  = tick_cnt_q;
  assign bit_index_o = bit_index_q;

  always_comb begin
    tick_cnt_d  = tick_cnt_q;
    bit_index_d = bit_index_q;
    if (clear_i) begin
      tick_cnt_d  = '0;
      bit_index_d = '0;
    end else if (advance_i) begin
      if (wrap_o) begin
        tick_cnt_d = '0;
        // The owner decides whether a wrap marks a new bit.
        if (bit_inc_i) bit_index_d = bit_index_q + 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q  <= '0;
      bit_index_q <= '0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      bit_index_q <= bit_index_d;
    end
  end

endmodule

// File: rtl/uart_rx_start_validator.sv
// UART Rx start-bit validator: majority-voted start detection, then mid-bit strobes per frame bit.
// Optional break detection is built when UART_RX_BREAK_DETECT_EN is defined.
module uart_rx_start_validator
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int PARITY_ENABLED = 1,
  parameter int STOP_BITS      = 1,
  localparam int FRAME_BITS    = frame_bits_f(DATA_WIDTH, PARITY_ENABLED, STOP_BITS),
  localparam int MID           = mid_f(OVERSAMPLE),
  localparam int TW            = $clog2(OVERSAMPLE),
  localparam int BW            = $clog2(FRAME_BITS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sample_tick,
  input  logic          serial_in_synced,
  output logic          start_detected,
  output logic          false_start,
  output logic          mid_strobe,
  output logic [BW-1:0] bit_index,
  output logic          busy,
  output logic          break_detected
);

  localparam logic [TW:0] MID_M1 = (TW+1)'(MID - 1);
  localparam logic [TW:0] MID_V  = (TW+1)'(MID);
  localparam logic [TW:0] MID_P1 = (TW+1)'(MID + 1);

  rx_start_state_t state_q, state_d;
  logic            prev_level_q, prev_level_d;
  logic [1:0]      vote_q, vote_d;
  logic            start_q, start_d;
  logic            false_q, false_d;
  logic            strobe_q, strobe_d;
  logic            last_strobe;

  logic [TW-1:0]   tick_cnt;
  logic [TW:0]     tick_next;
  logic            wrap;
  logic [2:0]      low_votes;

  uart_tick_counter #(
    .OVERSAMPLE (OVERSAMPLE),
    .FRAME_BITS (FRAME_BITS),
    .TW         (TW),
    .BW         (BW)
  ) u_tick_counter (
    .clk         (clk),
    .reset       (reset),
    .clear_i     ((state_q == IDLE) || (state_q == WAIT_IDLE)),
    .advance_i   (sample_tick && ((state_q == START_CHECK) || (state_q == HOLDOFF))),
    .bit_inc_i   (state_q == HOLDOFF),
    .tick_cnt_o  (tick_cnt),
    .bit_index_o (bit_index),
    .wrap_o      (wrap)
  );

  // Tick number counted from the falling edge (edge tick = 0) that the current sample_tick represents.
  assign tick_next = {1'b0, tick_cnt} + 1'b1;
  assign low_votes = {1'b0, vote_q} + {2'b00, ~serial_in_synced};

  always_comb begin
    state_d      = state_q;
    prev_level_d = prev_level_q;
    vote_d       = vote_q;
    start_d      = 1'b0;
    false_d      = 1'b0;
    strobe_d     = 1'b0;
    last_strobe  = 1'b0;
    if (sample_tick) prev_level_d = serial_in_synced;
    case (state_q)
      IDLE: begin
        vote_d = '0;
        if (sample_tick && prev_level_q && !serial_in_synced) state_d = START_CHECK;
      end
      START_CHECK: begin
        if (sample_tick) begin
          if (((tick_next == MID_M1) || (tick_next == MID_V)) && !serial_in_synced)
            vote_d = vote_q + 1'b1;
          if (tick_next == MID_P1) begin
            if (low_votes >= 3'd2) begin
              start_d = 1'b1;
              state_d = HOLDOFF;
            end else begin
              false_d = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end
      HOLDOFF: begin
        if (sample_tick && !wrap && (tick_next == MID_V)) begin
          strobe_d = 1'b1;
          if (bit_index == BW'(FRAME_BITS - 1)) begin
            last_strobe = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (sample_tick && serial_in_synced) begin
          state_d      = IDLE;
          prev_level_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      prev_level_q <= 1'b1;
      vote_q       <= '0;
      start_q      <= 1'b0;
      false_q      <= 1'b0;
      strobe_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_level_q <= prev_level_d;
      vote_q       <= vote_d;
      start_q      <= start_d;
      false_q      <= false_d;
      strobe_q     <= strobe_d;
    end
  end

  assign start_detected = start_q;
  assign false_start    = false_q;
  assign mid_strobe     = strobe_q;
  assign busy           = (state_q != IDLE);

`ifdef UART_RX_BREAK_DETECT_EN
  logic all_low_q, all_low_d;
  logic break_q, break_d;

  // all_low survives only if every mid-bit sample after the start bit was low.
  always_comb begin
    all_low_d = all_low_q;
    if (start_d) all_low_d = 1'b1;
    else if (strobe_d && serial_in_synced) all_low_d = 1'b0;
    break_d = last_strobe && all_low_q && !serial_in_synced;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      all_low_q <= 1'b0;
      break_q   <= 1'b0;
    end else begin
      all_low_q <= all_low_d;
      break_q   <= break_d;
    end
  end

  assign break_detected = break_q;
`else
  assign break_detected = 1'b0;
`endif

endmodule

// File: doc/uart_rx_start_validator.md
Name: uart_rx_start_validator

Overview:
- Next-generation UART receive front end for start-bit detection, parametrised in frame format and oversampling ratio.
- Detects the falling edge on the synchronised serial line and confirms it with a 3-sample majority vote around the start-bit centre. Glitches are rejected as false starts.
- After a valid start it produces mid-bit strobes and the bit index for the rest of the frame, and ignores edges until the frame ends and the line is idle again.
- Sits between the input synchroniser and the Rx shift/parity/stop logic.

Parameters:
- OVERSAMPLE, 16, sample_tick pulses per bit; even, at least 4.
- DATA_WIDTH, 8, data bits per frame.
- PARITY_ENABLED, 1, 1 adds a parity bit; 0 omits it.
- STOP_BITS, 1, stop bits per frame (1 or 2).
- Derived localparams:
  - FRAME_BITS = 1 + DATA_WIDTH + PARITY_ENABLED + STOP_BITS
  - MID = OVERSAMPLE/2
  - TW = $clog2(OVERSAMPLE)
  - BW = $clog2(FRAME_BITS)

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- sample_tick  input  1  oversampling enable; state advances only on clk edges where this is 1
- serial_in_synced  input  1  already-synchronised Rx line, idle high
- start_detected  output  1  one-cycle pulse when the start bit is confirmed
- false_start  output  1  one-cycle pulse when the start bit is rejected
- mid_strobe  output  1  one-cycle pulse at the centre of each bit after the start bit
- bit_index  output  BW  index of the bit being strobed; start bit = 0, first data bit = 1
- busy  output  1  high in every state except IDLE
- break_detected  output  1  one-cycle pulse (see Optional Feature)

Behaviour:
- Reset: state IDLE; prev_level=1; tick_cnt=0; bit_index=0; vote counters 0; all pulse outputs and busy are 0. Reset mid-frame aborts without any pulse.
- Pulse outputs are registered and high for exactly one clk. They never assert on consecutive cycles.
- prev_level updates to serial_in_synced only on sample_tick.
- FSM states: IDLE, START_CHECK, HOLDOFF, WAIT_IDLE.
- IDLE:
  - On sample_tick with prev_level=1 and serial_in_synced=0: go to START_CHECK, tick_cnt=0 (edge tick = tick 0).
- START_CHECK:
  - Each sample_tick increments tick_cnt.
  - The line is sampled at ticks MID-1, MID and MID+1.
  - On tick MID+1, decide by majority of the three samples:
    - 2 or more lows: start_detected on the next clk, go to HOLDOFF, bit_index stays 0.
    - Otherwise: false_start, go to IDLE.
- HOLDOFF:
  - tick_cnt wraps modulo OVERSAMPLE. Each wrap to 0 increments bit_index.
  - When tick_cnt==MID on a sample_tick: mid_strobe pulses with the current bit_index (1..FRAME_BITS-1).
  - At the strobe with bit_index==FRAME_BITS-1 (last stop bit): go to WAIT_IDLE.
  - Falling edges in HOLDOFF are ignored.
- WAIT_IDLE:
  - On the first sample_tick with serial_in_synced=1: go to IDLE, prev_level=1. A low line holds WAIT_IDLE indefinitely.
- Between frames: prev_level is forced to 1 on leaving WAIT_IDLE. A falling edge on the very next tick after that is a new start.
- Without sample_tick, no state or counter changes. Pulses raised on a tick edge still clear on the following clk.
- Framing and parity checks are downstream responsibilities, not part of this block.

Optional Feature:
- Macro: UART_RX_BREAK_DETECT_EN.
- Defined:
  - In HOLDOFF a flag all_low is set at start and cleared by any mid-bit sample of 1.
  - At the last stop-bit strobe, if all_low is still 1, break_detected pulses together with mid_strobe. The FSM then enters WAIT_IDLE as normal.
- Undefined: the break_detected port still exists and is tied to 0, and no all_low logic is built.

Decomposition:
- Package uart_rx_pkg holds:
  - the rx_start_state_t enum (IDLE, START_CHECK, HOLDOFF, WAIT_IDLE)
  - a FRAME_BITS helper function
  - the MID calculation
- One sub-module: uart_tick_counter, the mod-OVERSAMPLE tick counter plus bit_index counter, with a clear input and a wrap output. The FSM and vote logic stay in the top module.

Test Plan:
All scenarios use default parameters: FRAME_BITS=11, MID=8, one sample_tick every 4 clk.
- Clean frame 0xA5, parity 0, stop 1 → start_detected once, at the clk after tick 9. mid_strobe 10 times at ticks 24, 40, …, 168 with bit_index 1..10. busy falls one tick after the stop bit is seen high. No false_start.
- Line low for only ticks 0–3 (glitch) → false_start at tick 9; no start_detected, no mid_strobe; busy 0 afterwards.
- Low at ticks 0–7 and 9, high at tick 8 → majority low, so start_detected is asserted.
- Falling edge injected at tick 40 mid-frame → ignored; strobe count stays 10.
- Line held low for 11 bits, then high → with the macro, break_detected at tick 168 and WAIT_IDLE holds until the line is high. Without the macro, break_detected stays 0.
- Reset asserted at tick 50 of a frame → next clk: busy=0, all outputs 0. A new start 2 ticks after reset release is detected normally.
